mem_resp: RTL and testbench
===========================

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width of the internal store (depth 2**ADDR_W x 16-bit words).
REQ-002 Parameter: WAIT_STATES, default 1, number of idle cycles between request capture and first data/ack cycle (0 legal, max 15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 asserts).
REQ-005 cs  input  1  chip select from the bus initiator; level request, held high until completion is seen.
REQ-006 sel  input  2  operation: 00 fetch (two-beat), 01 read, 10 write, 11 reserved.
REQ-007 addr  input  16  word address of the request.
REQ-008 wdata  input  16  write data, valid with cs when sel=10.
REQ-009 rdata  output  16  read/fetch data, valid only while ready=1, else 0.
REQ-010 ready  output  1  one-cycle completion strobe per data beat or write/error ack.
REQ-011 last  output  1  high with the final ready strobe of a transaction.
REQ-012 err  output  1  high with ready when the request is rejected.

Function
REQ-013 States SHALL be IDLE, WAIT, BEAT0, BEAT1, HOLD.
REQ-014 IDLE: cs=1 SHALL capture sel, addr, wdata into registers and go to WAIT (WAIT_STATES>0) or BEAT0 (WAIT_STATES=0); captured values unaffected by later input changes.
REQ-015 WAIT SHALL last exactly WAIT_STATES cycles via a down-counter, then go to BEAT0.
REQ-016 Error check in BEAT0: sel=11 or addr[15:ADDR_W] nonzero SHALL give ready=1, err=1, last=1, rdata=0, no store access, then HOLD.
REQ-017 Read (01), BEAT0: rdata=mem[addr[ADDR_W-1:0]], ready=1, last=1, then HOLD.
REQ-018 Write (10), BEAT0: mem[addr] SHALL be written with captured wdata at that cycle's edge; ready=1, last=1, rdata=0, then HOLD.
REQ-019 Fetch (00), BEAT0: rdata=mem[addr], ready=1, last=0, then BEAT1.
REQ-020 Fetch BEAT1 (next cycle): rdata=mem[(addr+1) mod 2**ADDR_W], ready=1, last=1, then HOLD; addr at top of store wraps to word 0 without error.
REQ-021 First ready after capture SHALL occur WAIT_STATES+1 cycles after the capturing edge.
REQ-022 HOLD SHALL keep ready/last/err low and return to IDLE only when cs=0; a new request needs cs to fall then rise again.
REQ-023 cs=0 in WAIT or BEAT0/BEAT1 (before the final beat) SHALL abort: no ready, no store write, next state IDLE.
REQ-024 cs low in the same cycle as BEAT0 of a write SHALL abort the write (REQ-023 takes priority).
REQ-025 ready, last, err SHALL be registered outputs; rdata combinationally gated to 0 when ready=0 or err=1.
REQ-026 Store contents SHALL persist across transactions; no read-modify-write, no byte enables.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, wait counter 0, ready=0, last=0, err=0, rdata=0, captured registers 0.
REQ-028 Store contents SHALL NOT be cleared by reset and are undefined until written.
REQ-029 reset asserted mid-transaction SHALL abandon it with no ready strobe and no store write; reset release with cs=1 SHALL start a new capture on the first active edge.

Verification
REQ-030 WAIT_STATES=1: write addr=0x0010 wdata=0xBEEF -> ready=last=1, err=0 exactly 2 cycles after capture; then read 0x0010 -> rdata=0xBEEF with ready, last=1.
REQ-031 Write 0x00FF=0x1234 and 0x0000=0x5678, fetch addr=0x00FF -> beat0 rdata=0x1234 last=0, next cycle rdata=0x5678 last=1.
REQ-032 Request sel=11, and separately read addr=0x0100 (ADDR_W=8) -> single ready with err=1, last=1, rdata=0, store unchanged.
REQ-033 Write 0x0020=0xAAAA, then write 0x0020=0x5555 with cs dropped during WAIT -> no ready; read 0x0020 returns 0xAAAA.
REQ-034 Hold cs=1 after a read completes -> no second ready for 10 cycles; drop cs one cycle then raise -> new transaction served.
REQ-035 Assert reset during fetch BEAT0 -> ready/last/err/rdata 0 immediately; after release, read of previously written address returns prior data.

Source files
------------

// File: rtl/mem_resp.sv
// Single-port word store behind a cs/ready request bus.
// A request is captured on cs, optionally delayed by a fixed number of
// wait states, then answered with one (read/write/error) or two (fetch)
// registered ready strobes. The initiator must drop cs before the next
// request is accepted.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for cs; captures sel/addr/wdata when it rises
// ST_WAIT  | counting down the configured wait states
// ST_BEAT0 | first beat: error check, read, write or first fetch word
// ST_BEAT1 | second fetch word (address + 1, wrapping inside the store)
// ST_HOLD  | transaction done; waits for cs to fall before going idle
module mem_resp #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  sel,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        last,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT0,
        ST_BEAT1,
        ST_HOLD
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [15:0]       store [2**ADDR_W];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        sel_q;
    logic [15:0]       addr_q, wdata_q;
    logic [15:0]       data_q, data_d;
    logic              ready_d, last_d, err_d;
    logic              capture, store_we, bad_req;
    logic [ADDR_W-1:0] idx, idx_next;

    assign idx      = addr_q[ADDR_W-1:0];
    assign idx_next = idx + ADDR_W'(1);
    assign bad_req  = (sel_q == 2'b11) || ((addr_q >> ADDR_W) != 16'd0);

    // Data is only driven onto the bus during a successful beat.
    assign rdata = (ready && !err) ? data_q : 16'd0;

    // State, counter, captured request and registered response flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 2'b00;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            data_q  <= 16'd0;
            ready   <= 1'b0;
            last    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready   <= ready_d;
            last    <= last_d;
            err     <= err_d;
            if (capture) begin
                sel_q   <= sel;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // Store write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store[idx] <= wdata_q;
        end
    end

    // Next-state and next-response logic; cs low before the final beat aborts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        ready_d  = 1'b0;
        last_d   = 1'b0;
        err_d    = 1'b0;
        capture  = 1'b0;
        store_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs) begin
                    capture = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_BEAT0;
                    end
                end
            end
            ST_WAIT: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_BEAT0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_BEAT0: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                end else if (bad_req) begin
                    ready_d = 1'b1;
                    last_d  = 1'b1;
                    err_d   = 1'b1;
                    data_d  = 16'd0;
                    state_d = ST_HOLD;
                end else begin
                    ready_d = 1'b1;
                    case (sel_q)
                        2'b00: begin
                            data_d  = store[idx];
                            state_d = ST_BEAT1;
                        end
                        2'b01: begin
                            data_d  = store[idx];
                            last_d  = 1'b1;
                            state_d = ST_HOLD;
                        end
                        default: begin
                            store_we = 1'b1;
                            data_d   = 16'd0;
                            last_d   = 1'b1;
                            state_d  = ST_HOLD;
                        end
                    endcase
                end
            end
            ST_BEAT1: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                end else begin
                    data_d  = store[idx_next];
                    ready_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp (ADDR_W=8, WAIT_STATES=1). Expected beats are
// queued as requests are issued and checked by a negedge monitor.
module tb_mem_resp;

    localparam int WS = 1;

    typedef struct packed {
        logic [15:0] rdata;
        logic        last;
        logic        err;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [15:0] addr = 16'd0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic        ready, last, err;

    beat_t       sb[$];
    logic [15:0] model [256];
    int          checks = 0;
    int          errors = 0;

    mem_resp #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .sel   (sel),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .last  (last),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: every ready strobe must match the oldest queued beat,
    // and the response outputs must be quiet between strobes.
    always @(negedge clk) begin
        beat_t e;
        if (reset === 1'b1) begin
            if (ready === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_ready: observed=ready with rdata=%h expected=no beat", rdata);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat", 32'({rdata, last, err}), 32'({e.rdata, e.last, e.err}));
                end
            end else begin
                chk("idle_outputs", 32'({rdata, last, err}), 32'd0);
            end
        end
    end

    // Waits for the first ready after the capture edge and checks its latency.
    task automatic wait_first();
        int cyc = 0;
        while (ready !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(WS + 1));
    endtask

    task automatic req(input logic [1:0] s, input logic [15:0] a, input logic [15:0] wd, input int hold);
        logic [7:0] i;
        logic [7:0] i1;
        logic       bad;
        i   = a[7:0];
        i1  = i + 8'd1;
        bad = (s == 2'b11) || (a[15:8] != 8'd0);
        if (bad) begin
            sb.push_back('{16'd0, 1'b1, 1'b1});
        end else if (s == 2'b00) begin
            sb.push_back('{model[i], 1'b0, 1'b0});
            sb.push_back('{model[i1], 1'b1, 1'b0});
        end else if (s == 2'b01) begin
            sb.push_back('{model[i], 1'b1, 1'b0});
        end else begin
            sb.push_back('{16'd0, 1'b1, 1'b0});
            model[i] = wd;
        end
        @(negedge clk);
        cs = 1'b1; sel = s; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        sel = ~s; addr = ~a; wdata = ~wd;
        wait_first();
        if (s == 2'b00 && !bad) begin
            @(posedge clk);
            #1;
            chk("beat1_ready", 32'(ready), 32'd1);
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        cs = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_outputs", 32'({rdata, last, err}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        req(2'b10, 16'h0010, 16'hBEEF, 0);
        req(2'b01, 16'h0010, 16'h0000, 10);

        req(2'b10, 16'h00FF, 16'h1234, 0);
        req(2'b10, 16'h0000, 16'h5678, 0);
        req(2'b00, 16'h00FF, 16'h0000, 0);

        req(2'b11, 16'h0010, 16'hDEAD, 0);
        req(2'b01, 16'h0100, 16'h0000, 0);
        req(2'b10, 16'h0110, 16'hDEAD, 0);
        req(2'b01, 16'h0010, 16'h0000, 0);
        req(2'b00, 16'h0010, 16'h0000, 2);

        // Write aborted while waiting.
        req(2'b10, 16'h0020, 16'hAAAA, 0);
        @(negedge clk);
        cs = 1'b1; sel = 2'b10; addr = 16'h0020; wdata = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0;
        repeat (5) @(posedge clk);
        req(2'b01, 16'h0020, 16'h0000, 0);

        // Write aborted in the same cycle as its first beat.
        req(2'b10, 16'h0021, 16'h1111, 0);
        @(negedge clk);
        cs = 1'b1; sel = 2'b10; addr = 16'h0021; wdata = 16'h2222;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0;
        repeat (5) @(posedge clk);
        req(2'b01, 16'h0021, 16'h0000, 0);

        // Reset while the first fetch beat is being presented.
        @(negedge clk);
        cs = 1'b1; sel = 2'b00; addr = 16'h00FF;
        @(posedge clk);
        #1;
        wait_first();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(ready), 32'd0);
        chk("rst_mid_last", 32'(last), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_rdata", 32'(rdata), 32'd0);
        // Release reset with cs still high: a fresh read is captured at once.
        @(negedge clk);
        sel = 2'b01; addr = 16'h00FF;
        sb.push_back('{model[8'hFF], 1'b1, 1'b0});
        reset = 1'b1;
        @(posedge clk);
        #1;
        wait_first();
        @(negedge clk);
        cs = 1'b0;
        req(2'b01, 16'h0000, 16'h0000, 0);

        repeat (4) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
